// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared pipeline types and constants for the hazard controller
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int          REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSN  = 32'h00000013;

  // x0 is hard-wired to zero, so a load targeting it never blocks a consumer.
  function automatic logic load_use_hit(
    input logic                 mem_read,
    input logic [REG_IDX_W-1:0] rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 use_rs1,
    input logic                 use_rs2
  );
    return mem_read && (rd != '0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_sequencer.sv
// rtl/pipeline_hazard_ctrl_md_sequencer.sv - fixed-latency mul/div sequencer (IDLE/RUN FSM and down-counter)
module md_sequencer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ex_mul,
  input  logic ex_div,
  output logic md_start,
  output logic md_done,
  output logic md_busy,
  output logic md_hold
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  md_state_e     state;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic [CW-1:0] load_val;

  assign load_val = ex_div ? DIV_LOAD : MUL_LOAD;

  // done_q mirrors "RUN with cnt==0" so the done cycle is a registered flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_mul || ex_div) begin
            state  <= RUN;
            cnt    <= load_val;
            done_q <= (load_val == '0);
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            done_q <= (cnt == CW'(1));
          end else begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // The start cycle must stall combinationally; gate on reset so outputs stay quiet in reset.
  assign md_start = rst_n && (state == IDLE) && (ex_mul || ex_div);
  assign md_busy  = (state == RUN);
  assign md_done  = done_q;
  assign md_hold  = md_start || ((state == RUN) && !done_q);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/bubble control; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [REG_IDX_W-1:0] ID_RS1,
  input  logic [REG_IDX_W-1:0] ID_RS2,
  input  logic                 ID_USES_RS1,
  input  logic                 ID_USES_RS2,
  input  logic [REG_IDX_W-1:0] EX_RD,
  input  logic                 EX_MEM_READ,
  input  logic                 EX_BRANCH_SELECT,
  input  logic                 EX_MUL,
  input  logic                 EX_DIV,
  output logic                 PC_STALL,
  output logic                 IF_ID_STALL,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_STALL,
  output logic                 ID_EX_FLUSH,
  output logic                 EX_MEM_BUBBLE,
  output logic                 MD_START,
  output logic                 MD_DONE,
  output logic                 MD_BUSY
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          STALL_COUNT,
  output logic [31:0]          FLUSH_COUNT
`endif
);

  logic md_hold;
  logic lu;

  md_sequencer #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_sequencer (
    .clk     (CLK),
    .rst_n   (RST),
    .ex_mul  (EX_MUL),
    .ex_div  (EX_DIV),
    .md_start(MD_START),
    .md_done (MD_DONE),
    .md_busy (MD_BUSY),
    .md_hold (md_hold)
  );

  assign lu = load_use_hit(EX_MEM_READ, EX_RD, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2);

  // Priority: mul/div hold, then branch squash, then load-use; LU is ignored while RUN.
  always_comb begin
    PC_STALL      = 1'b0;
    IF_ID_STALL   = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_STALL   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    if (!RST) begin
      PC_STALL = 1'b0;
    end else if (md_hold) begin
      PC_STALL      = 1'b1;
      IF_ID_STALL   = 1'b1;
      ID_EX_STALL   = 1'b1;
      EX_MEM_BUBBLE = 1'b1;
    end else if (MD_BUSY) begin
      PC_STALL = 1'b0;
    end else if (EX_BRANCH_SELECT) begin
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (lu) begin
      PC_STALL    = 1'b1;
      IF_ID_STALL = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      STALL_COUNT <= '0;
      FLUSH_COUNT <= '0;
    end else begin
      if (PC_STALL && (STALL_COUNT != 32'hFFFF_FFFF)) STALL_COUNT <= STALL_COUNT + 32'd1;
      if (IF_ID_FLUSH && (FLUSH_COUNT != 32'hFFFF_FFFF)) FLUSH_COUNT <= FLUSH_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl (two latency configurations)
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch, ex_mul, ex_div;
  wire  [8:0] out_a, out_b;
  wire  [31:0] sc_a, fc_a, sc_b, fc_b;

  int compared = 0;
  int mismatched = 0;
  int k[2] = '{-1, -1};
  int cur_lat[2] = '{1, 1};
  int mul_lat[2] = '{1, 3};
  int div_lat[2] = '{32, 5};
  longint exp_sc[2] = '{0, 0};
  longint exp_fc[2] = '{0, 0};
  int cyc = 0;
  int stall_a = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int s1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(32)) dut_a (
    .CLK(clk), .RST(rst), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2), .EX_RD(ex_rd),
    .EX_MEM_READ(ex_mem_read), .EX_BRANCH_SELECT(ex_branch), .EX_MUL(ex_mul), .EX_DIV(ex_div),
    .PC_STALL(out_a[8]), .IF_ID_STALL(out_a[7]), .IF_ID_FLUSH(out_a[6]), .ID_EX_STALL(out_a[5]),
    .ID_EX_FLUSH(out_a[4]), .EX_MEM_BUBBLE(out_a[3]), .MD_START(out_a[2]), .MD_DONE(out_a[1]),
    .MD_BUSY(out_a[0])
`ifdef HAZARD_PERF_CNT_EN
    , .STALL_COUNT(sc_a), .FLUSH_COUNT(fc_a)
`endif
  );

  pipeline_hazard_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(5)) dut_b (
    .CLK(clk), .RST(rst), .ID_RS1(id_rs1), .ID_RS2(id_rs2),
    .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2), .EX_RD(ex_rd),
    .EX_MEM_READ(ex_mem_read), .EX_BRANCH_SELECT(ex_branch), .EX_MUL(ex_mul), .EX_DIV(ex_div),
    .PC_STALL(out_b[8]), .IF_ID_STALL(out_b[7]), .IF_ID_FLUSH(out_b[6]), .ID_EX_STALL(out_b[5]),
    .ID_EX_FLUSH(out_b[4]), .EX_MEM_BUBBLE(out_b[3]), .MD_START(out_b[2]), .MD_DONE(out_b[1]),
    .MD_BUSY(out_b[0])
`ifdef HAZARD_PERF_CNT_EN
    , .STALL_COUNT(sc_b), .FLUSH_COUNT(fc_b)
`endif
  );

`ifndef HAZARD_PERF_CNT_EN
  assign sc_a = '0;
  assign fc_a = '0;
  assign sc_b = '0;
  assign fc_b = '0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: k counts the cycle index (0..LAT) of the op occupying EX; -1 means no op.
  function automatic logic [8:0] expect_out(input int d);
    logic [8:0] e;
    logic busy, start, done, hold, lu;
    e = '0;
    if (!rst) return e;
    busy  = (k[d] >= 0);
    start = !busy && (ex_mul || ex_div);
    done  = busy && (k[d] == cur_lat[d]);
    hold  = start || (busy && (k[d] < cur_lat[d]));
    lu    = ex_mem_read && (ex_rd != 0) &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e[2] = start;
    e[1] = done;
    e[0] = busy;
    if (hold) begin
      e[8] = 1'b1; e[7] = 1'b1; e[5] = 1'b1; e[3] = 1'b1;
    end else if (!busy) begin
      if (ex_branch) begin
        e[6] = 1'b1; e[4] = 1'b1;
      end else if (lu) begin
        e[8] = 1'b1; e[7] = 1'b1; e[4] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic advance(input int d, input logic [8:0] e);
    if (!rst) begin
      k[d] = -1;
      exp_sc[d] = 0;
      exp_fc[d] = 0;
    end else begin
      if (e[8] && exp_sc[d] != 64'hFFFF_FFFF) exp_sc[d]++;
      if (e[6] && exp_fc[d] != 64'hFFFF_FFFF) exp_fc[d]++;
      if (k[d] < 0) begin
        if (ex_mul || ex_div) begin
          cur_lat[d] = ex_div ? div_lat[d] : mul_lat[d];
          k[d] = 1;
        end
      end else if (k[d] == cur_lat[d]) begin
        k[d] = -1;
      end else begin
        k[d]++;
      end
    end
  endtask

  task automatic step(input string tag);
    logic [8:0] ea, eb;
    @(negedge clk);
    ea = expect_out(0);
    eb = expect_out(1);
    check({tag, "_a"}, {23'd0, out_a}, {23'd0, ea});
    check({tag, "_b"}, {23'd0, out_b}, {23'd0, eb});
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cnt_a"}, sc_a, rst ? exp_sc[0][31:0] : 32'd0);
    check({tag, "_flush_cnt_a"}, fc_a, rst ? exp_fc[0][31:0] : 32'd0);
    check({tag, "_stall_cnt_b"}, sc_b, rst ? exp_sc[1][31:0] : 32'd0);
    check({tag, "_flush_cnt_b"}, fc_b, rst ? exp_fc[1][31:0] : 32'd0);
`endif
    if (out_a[8]) stall_a++;
    if (out_a[2]) start_cyc = cyc;
    if (out_a[1]) done_cyc = cyc;
    cyc++;
    @(posedge clk);
    #1;
    advance(0, ea);
    advance(1, eb);
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_branch = 1'b0; ex_mul = 1'b0; ex_div = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    step("reset_idle");
    ex_div = 1'b1;
    ex_branch = 1'b0;
    step("reset_with_div");
    clear_inputs();
    step("reset_idle2");
    rst = 1'b1;
    step("post_reset");

    // load x5 in EX, consumer reads it via rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    stall_a = 0;
    step("lu_x5");
    clear_inputs();
    step("lu_release");
    check("lu_one_stall", stall_a, 1);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1; id_uses_rs1 = 1'b1;
    stall_a = 0;
    step("lu_x0");
    check("lu_x0_no_stall", stall_a, 0);

    // branch overrides a concurrent load-use match
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; ex_branch = 1'b1;
    step("branch_lu");
    clear_inputs();
    step("branch_release");

    ex_div = 1'b1;
    stall_a = 0;
    repeat (33) step("div");
    ex_div = 1'b0;
    check("div_stall_cycles", stall_a, 32);
    check("div_done_latency", done_cyc - start_cyc, 32);
    repeat (6) step("div_drain");

    ex_mul = 1'b1;
    stall_a = 0;
    repeat (2) step("mul1");
    check("mul1_done_latency", done_cyc - start_cyc, 1);
    s1 = start_cyc;
    repeat (2) step("mul1_b2b");
    check("mul1_b2b_start", start_cyc - s1, 2);
    check("mul1_stall_cycles", stall_a, 2);
    ex_mul = 1'b0;
    repeat (8) step("mul_drain");

    // reset during a divide aborts immediately
    ex_div = 1'b1;
    repeat (11) step("div_pre_rst");
    rst = 1'b0;
    #1;
    check("rst_async_outputs", {14'd0, out_a, out_b}, 32'd0);
    repeat (2) step("div_in_rst");
    rst = 1'b1;
    stall_a = 0;
    repeat (33) step("div_after_rst");
    ex_div = 1'b0;
    check("div_after_rst_stalls", stall_a, 32);
    repeat (6) step("rst_drain");

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b0;
    step("perf_rst");
    rst = 1'b1;
    ex_div = 1'b1;
    repeat (33) step("perf_div");
    ex_div = 1'b0;
    step("perf_gap");
    ex_branch = 1'b1;
    step("perf_branch");
    ex_branch = 1'b0;
    step("perf_end");
    check("perf_stall_count", sc_a, 32'd32);
    check("perf_flush_count", fc_a, 32'd1);
    repeat (6) step("perf_drain");
`endif

    repeat (400) begin
      int r;
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 15));
      ex_mul = (r == 0);
      ex_div = (r == 1);
      ex_branch = (r > 1) && ($urandom_range(0, 7) == 0);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the five-stage RV32IM pipeline. It generates stall, flush and bubble controls for the PC, IF_ID, ID_EX and EX_MEM registers. It detects load-use hazards between the ID and EX stages and squashes wrong-path instructions on a taken branch or jump. It also sequences the fixed-latency multiply/divide unit in EX, holding the pipeline until that unit's result is ready.

## Interface
Parameters:
- MUL_CYCLES, 2: multiply result latency in cycles; minimum 1.
- DIV_CYCLES, 32: divide/remainder latency in cycles; at least MUL_CYCLES.

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- ID_RS1, ID_RS2  in  5  source register indices of the instruction in ID.
- ID_USES_RS1, ID_USES_RS2  in  1  the ID instruction reads that source.
- EX_RD  in  5  destination register of the instruction in EX.
- EX_MEM_READ  in  1  the EX instruction is a load.
- EX_BRANCH_SELECT  in  1  taken branch or jump resolved in EX.
- EX_MUL, EX_DIV  in  1  the EX instruction is an M-extension multiply or divide; never both high.
- PC_STALL  out  1  hold the PC.
- IF_ID_STALL  out  1  hold IF_ID.
- IF_ID_FLUSH  out  1  load a NOP into IF_ID.
- ID_EX_STALL  out  1  hold ID_EX.
- ID_EX_FLUSH  out  1  load a bubble (all control bits 0) into ID_EX.
- EX_MEM_BUBBLE  out  1  load a bubble into EX_MEM.
- MD_START  out  1  one-cycle start pulse to the mul/div unit.
- MD_DONE  out  1  the mul/div result is valid this cycle.
- MD_BUSY  out  1  the FSM is in RUN.

## Operation
- FSM states are IDLE and RUN. There is a down-counter CNT of width $clog2(DIV_CYCLES).
- Load-use hazard: LU = EX_MEM_READ && EX_RD!=0 && ((ID_USES_RS1 && ID_RS1==EX_RD) || (ID_USES_RS2 && ID_RS2==EX_RD)).
  - On LU: PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1, for exactly one cycle per occurrence.
- Taken branch: when EX_BRANCH_SELECT=1, IF_ID_FLUSH=1 and ID_EX_FLUSH=1. PC_STALL stays 0 so the PC loads the target.
- Mul/div start: in IDLE with EX_MUL or EX_DIV high:
  - MD_START=1.
  - CNT loads LAT-1, where LAT is MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - PC_STALL, IF_ID_STALL, ID_EX_STALL and EX_MEM_BUBBLE are asserted.
- RUN with CNT!=0: CNT decrements and all four hold/bubble signals stay asserted.
- RUN with CNT==0:
  - MD_DONE=1.
  - Hold/bubble signals drop, so EX_MEM captures the result and ID_EX advances.
  - Go to IDLE.
- Special case LAT=1: the start cycle enters RUN with CNT=0, and the next cycle is the done cycle.
- Priority when events coincide:
  - Mul/div stall overrides LU and branch. EX_BRANCH_SELECT cannot coincide with a mul/div in EX.
  - Branch flush overrides LU: the ID instruction is squashed, so PC_STALL=0 and IF_ID_STALL=0.
  - LU during mul/div RUN is ignored and re-evaluated after release.
- x0 never causes a hazard.

## Timing
- LU and branch outputs are combinational from inputs in the same cycle; there is no registered latency.
- Mul/div timing:
  - The instruction occupies EX for LAT+1 cycles.
  - Upstream stall lasts LAT cycles: the start cycle plus LAT-1 RUN cycles.
  - MD_DONE asserts in the (LAT+1)th cycle.
- MD_START is a single-cycle pulse. It is not re-issued for the same instruction because ID_EX advances in the MD_DONE cycle.
- Reset values: while RST=0 every output is 0, the FSM is IDLE and CNT=0.
- Reset mid-RUN aborts immediately; the mul/div unit must discard its state on the same reset.
- Back-to-back mul/div: in the cycle after MD_DONE, a new EX_MUL or EX_DIV starts immediately from IDLE.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds two outputs.
  - STALL_COUNT, 32 bits: increments on each cycle with PC_STALL=1.
  - FLUSH_COUNT, 32 bits: increments on each cycle with IF_ID_FLUSH=1.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- HAZARD_PERF_CNT_EN undefined: these ports and registers do not exist, and behaviour is otherwise identical.

## Structure
- The shared pipeline package holds:
  - the FSM state typedef (IDLE, RUN);
  - the register-index width constant (5);
  - the NOP encoding 32'h00000013 used by IF_ID flush.
- One sub-module, md_sequencer, contains the FSM and CNT and produces MD_START, MD_DONE, MD_BUSY and the mul/div hold signal.
- The top level combines the hold signal with LU and branch using the priority rules above.

## Test plan
- Load-use: load x5 in EX (EX_MEM_READ=1, EX_RD=5), ID_RS2=5 with ID_USES_RS2=1 -> exactly one cycle of PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1. Repeat with EX_RD=0 -> no stall.
- Branch: EX_BRANCH_SELECT=1 together with a concurrent LU match -> IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_STALL=0.
- Divide: EX_DIV=1 with DIV_CYCLES=32 -> MD_START in cycle 0; stall signals high in cycles 0-31; MD_DONE in cycle 32; stalls low in cycle 32.
- MUL_CYCLES=1: EX_MUL=1 -> MD_START in cycle 0, MD_DONE in cycle 1, one stall cycle. A back-to-back MUL then gets MD_START in cycle 2.
- Reset: drive RST low at RUN cycle 10 of a divide -> all outputs 0 immediately. After RST returns high, the FSM is IDLE and a fresh EX_DIV takes the full 32 stall cycles.
- HAZARD_PERF_CNT_EN: one divide plus one branch -> STALL_COUNT=32, FLUSH_COUNT=1.
